// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one combinational glyph ROM between N_REQ text clients.
// Supports locked string bursts (capped at MAX_BURST beats) and a one-cycle registered response.
module font_rom_arbiter #(
  parameter int N_REQ     = 4,
  parameter int CODE_W    = 8,
  parameter int GLYPH_W   = 15,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*CODE_W-1:0]   req_code,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [GLYPH_W-1:0]        rsp_data,
  output logic [CODE_W-1:0]         rom_code,
  input  logic [GLYPH_W-1:0]        rom_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 8;
  localparam logic [CODE_W-1:0] SPACE_CODE = CODE_W'(8'h20);
  localparam logic [CNT_W-1:0]  MAX_CNT    = CNT_W'(MAX_BURST);
  localparam logic [PTR_W:0]    N_WIDE     = (PTR_W+1)'(N_REQ);
  localparam logic [PTR_W-1:0]  LAST_IDX   = PTR_W'(N_REQ-1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [GLYPH_W-1:0] rsp_data_q, rsp_data_d;

  logic [CODE_W-1:0]  code_arr [N_REQ];
  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W:0]     scan_idx;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_code
    assign code_arr[gi] = req_code[gi*CODE_W +: CODE_W];
  end

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // First requester at or after rr_ptr, wrapping around the client list.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_idx >= N_WIDE) begin
        scan_idx = scan_idx - N_WIDE;
      end
      if (!pick_valid && req[scan_idx[PTR_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    grant_any  = 1'b0;
    grant_idx  = '0;
    gnt        = '0;
    rom_code   = SPACE_CODE;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_any = 1'b1;
            grant_idx = pick_idx;
            if (req_lock[pick_idx] && (MAX_BURST > 1)) begin
              state_d    = ST_LOCKED;
              owner_d    = pick_idx;
              beat_cnt_d = CNT_W'(1);
            end else begin
              rr_ptr_d = wrap_inc(pick_idx);
            end
          end
        end
        ST_LOCKED: begin
          // Owner dropping req ends the burst with a one-cycle bubble.
          if (req[owner_q]) begin
            grant_any  = 1'b1;
            grant_idx  = owner_q;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (!req_lock[owner_q] || (beat_cnt_q + CNT_W'(1) == MAX_CNT)) begin
              state_d  = ST_IDLE;
              rr_ptr_d = wrap_inc(owner_q);
            end
          end else begin
            state_d  = ST_IDLE;
            rr_ptr_d = wrap_inc(owner_q);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (grant_any) begin
      gnt[grant_idx] = 1'b1;
      rom_code       = code_arr[grant_idx];
    end
  end

  always_comb begin
    rsp_valid_d = gnt;
    rsp_data_d  = grant_any ? rom_data : rsp_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule
